// File: rtl/nbody_pair_sched.sv
// nbody_pair_sched: walks every ordered body pair (i,j), i!=j, into the getAccl pipeline
// and carries {valid, i, first, last} tags alongside it for the accumulator.
module nbody_pair_sched #(
    parameter int BODIES   = 512,
    parameter int IDX_W    = $clog2(BODIES),
    parameter int RD_LAT   = 1,
    parameter int ACCL_LAT = 58
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [IDX_W:0]   num_bodies,
    input  logic             issue_ready,
    output logic [IDX_W-1:0] rd_i,
    output logic [IDX_W-1:0] rd_j,
    output logic             rd_valid,
    output logic             accl_valid,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_i,
    output logic             out_first,
    output logic             out_last,
    output logic             busy,
    output logic             done
);
    localparam int D = RD_LAT + ACCL_LAT;
    localparam logic [IDX_W:0] N_MAX = (IDX_W+1)'(BODIES);
    localparam logic [IDX_W:0] ONE = (IDX_W+1)'(1);
    localparam logic [IDX_W:0] TWO = (IDX_W+1)'(2);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W:0]          n_q, n_d, n_start, last_j, i_w, j_w, j_inc;
    logic [IDX_W-1:0]        i_q, i_d, j_q, j_d;
    logic                    first, last, empty;
    logic [D-1:0]            v_q, v_d, f_q, f_d, l_q, l_d;
    logic [D-1:0][IDX_W-1:0] t_q, t_d;

    always_comb begin
        n_start  = (num_bodies > N_MAX) ? N_MAX : num_bodies;
        i_w      = {1'b0, i_q};
        j_w      = {1'b0, j_q};
        last_j   = (i_w == n_q - ONE) ? n_q - TWO : n_q - ONE;
        first    = (i_q == '0) ? (j_q == IDX_W'(1)) : (j_q == '0);
        last     = (j_w == last_j);
        j_inc    = j_w + ONE;
        empty    = ~|v_q;
        rd_valid = (state_q == ISSUE) && issue_ready;
        done     = (state_q == DRAIN) && empty && !abort;
        busy     = (state_q != IDLE) && !done;
        state_d  = state_q;
        n_d      = n_q;
        i_d      = i_q;
        j_d      = j_q;
        if (state_q == IDLE && start) begin
            n_d     = n_start;
            i_d     = '0;
            j_d     = IDX_W'(1);
            state_d = (n_start >= TWO) ? ISSUE : DRAIN;
        end else if (rd_valid && last) begin
            // next i is at least 1, so its first partner is body 0
            i_d     = i_q + 1'b1;
            j_d     = '0;
            state_d = (i_w == n_q - ONE) ? DRAIN : ISSUE;
        end else if (rd_valid) begin
            j_d = (j_inc == i_w) ? j_q + IDX_W'(2) : j_inc[IDX_W-1:0];
        end else if (state_q == DRAIN && empty) begin
            state_d = IDLE;
        end
        if (abort) state_d = IDLE;
        v_d = abort ? '0 : {v_q[D-2:0], rd_valid};
        t_d = {t_q[D-2:0], i_q};
        f_d = {f_q[D-2:0], first};
        l_d = {l_q[D-2:0], last};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            v_q     <= '0;
            t_q     <= '0;
            f_q     <= '0;
            l_q     <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            i_q     <= i_d;
            j_q     <= j_d;
            v_q     <= v_d;
            t_q     <= t_d;
            f_q     <= f_d;
            l_q     <= l_d;
        end
    end

    assign rd_i       = i_q;
    assign rd_j       = j_q;
    assign accl_valid = v_q[RD_LAT-1];
    assign out_valid  = v_q[D-1];
    assign out_i      = t_q[D-1];
    assign out_first  = f_q[D-1];
    assign out_last   = l_q[D-1];
endmodule

// File: tb/tb_nbody_pair_sched.sv
// tb_nbody_pair_sched: directed and randomized passes checked against a pair-list
// model with per-cycle issue history.
module tb_nbody_pair_sched;
    localparam int BODIES   = 16;
    localparam int IDX_W    = 4;
    localparam int RD_LAT   = 1;
    localparam int ACCL_LAT = 4;
    localparam int D        = RD_LAT + ACCL_LAT;

    logic             clk = 0, rst_n = 0, start = 0, abort = 0, issue_ready = 1;
    logic [IDX_W:0]   num_bodies = '0;
    logic [IDX_W-1:0] rd_i, rd_j, out_i;
    logic             rd_valid, accl_valid, out_valid, out_first, out_last, busy, done;
    int               checks = 0, failures = 0;

    typedef struct {int i; int j; bit f; bit l;} pair_t;

    always #5 clk = ~clk;

    nbody_pair_sched #(
        .BODIES(BODIES), .IDX_W(IDX_W), .RD_LAT(RD_LAT), .ACCL_LAT(ACCL_LAT)
    ) dut (
        .clk(clk), .rst(rst_n), .start(start), .abort(abort), .num_bodies(num_bodies),
        .issue_ready(issue_ready), .rd_i(rd_i), .rd_j(rd_j), .rd_valid(rd_valid),
        .accl_valid(accl_valid), .out_valid(out_valid), .out_i(out_i),
        .out_first(out_first), .out_last(out_last), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_accl_valid"}, accl_valid, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_first"}, out_first, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_rd_i"}, rd_i, 0);
        chk({tag, "_rd_j"}, rd_j, 0);
        chk({tag, "_out_i"}, out_i, 0);
    endtask

    // One pass: start in cycle 0, then check every cycle up to the predicted done.
    task automatic run_pass(input int nb, input int pct, input int abort_at, input bit hold,
                            input bit [31:0] mask);
        pair_t pq[$];
        pair_t p;
        int    hist[int];
        int    n, total, nk, last_c, c, k, obs_issues;
        bit    ir, erv, edone;
        n = (nb > BODIES) ? BODIES : nb;
        for (int a = 0; a < n; a++)
            for (int b = 0; b < n; b++)
                if (b != a) begin
                    p.i = a; p.j = b; p.f = 0; p.l = 0;
                    pq.push_back(p);
                end
        total = pq.size();
        for (int x = 0; x < total; x++) begin
            pq[x].f = (x == 0) || (pq[x-1].i != pq[x].i);
            pq[x].l = (x == total - 1) || (pq[x+1].i != pq[x].i);
        end
        @(posedge clk); #1;
        start = 1; abort = 0; issue_ready = 1;
        num_bodies = (IDX_W+1)'(nb);
        @(negedge clk);
        chk("c0_busy", busy, 0);
        chk("c0_done", done, 0);
        chk("c0_rd_valid", rd_valid, 0);
        nk = 0; last_c = 0; edone = 0; c = 0; obs_issues = 0;
        while (!edone) begin
            c++;
            @(posedge clk); #1;
            start = hold;
            num_bodies = (IDX_W+1)'($urandom_range(31));
            ir = !(c < 32 && mask[c]) && ($urandom_range(99) >= pct);
            issue_ready = ir;
            abort = (c == abort_at);
            if (abort) start = 1;
            @(negedge clk);
            erv = (nk < total) && ir;
            chk("rd_valid", rd_valid, erv);
            if (rd_valid === 1'b1) obs_issues++;
            if (erv) begin
                chk("rd_i", rd_i, pq[nk].i);
                chk("rd_j", rd_j, pq[nk].j);
                hist[c] = nk;
                nk++;
                if (nk == total) last_c = c;
            end
            chk("accl_valid", accl_valid, hist.exists(c - RD_LAT));
            chk("out_valid", out_valid, hist.exists(c - D));
            if (hist.exists(c - D)) begin
                k = hist[c - D];
                chk("out_i", out_i, pq[k].i);
                chk("out_first", out_first, pq[k].f);
                chk("out_last", out_last, pq[k].l);
            end
            edone = (total == 0) ? (c == 1) : (nk == total && c == last_c + D + 1);
            if (c == abort_at) edone = 0;
            chk("done", done, edone);
            chk("busy", busy, !edone);
            if (c == abort_at) begin
                @(posedge clk); #1;
                abort = 0; start = 0;
                @(negedge clk);
                chk("abort_busy", busy, 0);
                chk("abort_out_valid", out_valid, 0);
                chk("abort_accl_valid", accl_valid, 0);
                chk("abort_rd_valid", rd_valid, 0);
                chk("abort_done", done, 0);
                return;
            end
            if (c > 4000) begin
                checks++;
                failures++;
                $error("FAIL timeout observed=%0d expected_done_by=%0d", c, 4000);
                return;
            end
        end
        chk("issues", obs_issues, n * (n - 1));
    endtask

    initial begin
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1;
        run_pass(3, 0, 0, 0, 0);
        run_pass(3, 0, 0, 0, 32'b1100);
        run_pass(1, 0, 0, 0, 0);
        run_pass(0, 0, 0, 0, 0);
        run_pass(20, 0, 0, 0, 0);
        run_pass(3, 0, 3, 0, 0);
        run_pass(3, 0, 0, 0, 0);
        run_pass(4, 20, 0, 1, 0);
        run_pass(4, 20, 0, 0, 0);
        for (int r = 0; r < 4; r++) run_pass(int'($urandom_range(16)), 25, 0, 0, 0);
        @(posedge clk); #1;
        start = 1; num_bodies = 5'd5; issue_ready = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 0;
        #1 chk_reset("midrst");
        @(negedge clk);
        @(negedge clk);
        chk_reset("midrst_hold");
        rst_n = 1;
        run_pass(3, 0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
